// File: rtl/wb.sv
// ---------------------------------------------------------------------------
// wb -- write-back stage of the five-stage pipeline.
//
// Latches the MEM->WB bus under a valid/allow-in handshake, retires one
// instruction per cycle into a 32x32 register file (x0 hardwired to zero),
// serves the two decode read ports, exports the WB destination for hazard
// detection, drives the debug trace and counts retired instructions.
//
// Ports:
//   clk, rst_n            pipeline clock, async active-low reset
//   mem2wb_bus_i[69:0]    {wdest[4:0], we, result[31:0], pc[31:0]}
//   ctl_mem_over_i        MEM has an instruction leaving this cycle
//   ctl_wb_stall_i        external hold of the WB instruction
//   ctl_wb_allowin_o      WB accepts a new instruction at the next edge
//   ctl_wb_dest_o         dest of valid WB instruction (0 if none / we=0)
//   rf_raddr1/2_i         decode read addresses
//   rf_rdata1/2_o         combinational read data
//   debug_wb_*            trace of the committed write
//   wb_retire_cnt_o       retired instruction count (wraps)
//
// Build option:
//   WB_RF_BYPASS_EN  defined -> read ports see the committing write in the
//                    same cycle (write-first). Undefined -> array contents
//                    only; decode must use ctl_wb_dest_o as a hazard.
// ---------------------------------------------------------------------------
module wb #(
    parameter int RF_DEPTH = 32,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [69:0]      mem2wb_bus_i,
    input  logic             ctl_mem_over_i,
    input  logic             ctl_wb_stall_i,
    output logic             ctl_wb_allowin_o,
    output logic [4:0]       ctl_wb_dest_o,
    input  logic [4:0]       rf_raddr1_i,
    input  logic [4:0]       rf_raddr2_i,
    output logic [31:0]      rf_rdata1_o,
    output logic [31:0]      rf_rdata2_o,
    output logic [31:0]      debug_wb_pc_o,
    output logic             debug_wb_rf_we_o,
    output logic [4:0]       debug_wb_rf_wnum_o,
    output logic [31:0]      debug_wb_rf_wdata_o,
    output logic [CNT_W-1:0] wb_retire_cnt_o
);

    localparam int MEM2WBBusSize = 70;

    logic                     wb_valid;
    logic [MEM2WBBusSize-1:0] wb_bus_r;
    logic [31:0]              rf [RF_DEPTH];
    logic [CNT_W-1:0]         retire_cnt;

    logic [4:0]  wdest_r;
    logic        we_r;
    logic [31:0] result_r;
    logic [31:0] pc_r;
    logic        ready_go;
    logic        allowin;
    logic        retire;
    logic        wr;

    assign wdest_r  = wb_bus_r[69:65];
    assign we_r     = wb_bus_r[64];
    assign result_r = wb_bus_r[63:32];
    assign pc_r     = wb_bus_r[31:0];

    assign ready_go = !ctl_wb_stall_i;
    assign allowin  = !wb_valid || ready_go;
    assign retire   = wb_valid && ready_go;
    assign wr       = retire && we_r && (wdest_r != 5'd0);

    // Pipeline register: a stalled instruction holds and the upstream bus
    // is ignored until the stall drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_bus_r <= '0;
        end else if (allowin) begin
            wb_valid <= ctl_mem_over_i;
            if (ctl_mem_over_i) begin
                wb_bus_r <= mem2wb_bus_i;
            end
        end
    end

    // Register file; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (wr) begin
            rf[wdest_r] <= result_r;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (retire) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    function automatic logic [31:0] rf_read(input logic [4:0] addr);
        logic [31:0] data;
        if (addr == 5'd0) begin
            data = '0;
        end else begin
`ifdef WB_RF_BYPASS_EN
            data = (wr && (addr == wdest_r)) ? result_r : rf[addr];
`else
            data = rf[addr];
`endif
        end
        return data;
    endfunction

    assign rf_rdata1_o = rf_read(rf_raddr1_i);
    assign rf_rdata2_o = rf_read(rf_raddr2_i);

    assign ctl_wb_allowin_o    = allowin;
    assign ctl_wb_dest_o       = wdest_r & {5{wb_valid & we_r}};
    assign debug_wb_pc_o       = pc_r & {32{wb_valid}};
    assign debug_wb_rf_we_o    = wr;
    assign debug_wb_rf_wnum_o  = wdest_r & {5{wr}};
    assign debug_wb_rf_wdata_o = result_r & {32{wr}};
    assign wb_retire_cnt_o     = retire_cnt;

endmodule

// File: tb/tb_wb.sv
module tb_wb;

    logic        clk;
    logic        rst_n;
    logic [69:0] bus;
    logic        mem_over;
    logic        stall;
    logic        allowin;
    logic [4:0]  dest;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [31:0] dbg_pc;
    logic        dbg_we;
    logic [4:0]  dbg_wnum;
    logic [31:0] dbg_wdata;
    logic [31:0] cnt;

    // Narrow-counter copy fed with the same stimulus, used to observe wrap.
    logic        w_allowin;
    logic [4:0]  w_dest;
    logic [31:0] w_rdata1, w_rdata2, w_pc, w_wdata;
    logic        w_we;
    logic [4:0]  w_wnum;
    logic [3:0]  w_cnt;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef WB_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb dut (
        .clk(clk), .rst_n(rst_n),
        .mem2wb_bus_i(bus), .ctl_mem_over_i(mem_over), .ctl_wb_stall_i(stall),
        .ctl_wb_allowin_o(allowin), .ctl_wb_dest_o(dest),
        .rf_raddr1_i(raddr1), .rf_raddr2_i(raddr2),
        .rf_rdata1_o(rdata1), .rf_rdata2_o(rdata2),
        .debug_wb_pc_o(dbg_pc), .debug_wb_rf_we_o(dbg_we),
        .debug_wb_rf_wnum_o(dbg_wnum), .debug_wb_rf_wdata_o(dbg_wdata),
        .wb_retire_cnt_o(cnt)
    );

    wb #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .mem2wb_bus_i(bus), .ctl_mem_over_i(mem_over), .ctl_wb_stall_i(stall),
        .ctl_wb_allowin_o(w_allowin), .ctl_wb_dest_o(w_dest),
        .rf_raddr1_i(raddr1), .rf_raddr2_i(raddr2),
        .rf_rdata1_o(w_rdata1), .rf_rdata2_o(w_rdata2),
        .debug_wb_pc_o(w_pc), .debug_wb_rf_we_o(w_we),
        .debug_wb_rf_wnum_o(w_wnum), .debug_wb_rf_wdata_o(w_wdata),
        .wb_retire_cnt_o(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] d, input logic w, input logic [31:0] r, input logic [31:0] p);
        bus      = {d, w, r, p};
        mem_over = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; bus = '0; mem_over = 1'b0; stall = 1'b0;
        raddr1 = '0; raddr2 = '0;
        step(); step();
        #1;
        check("rst_allowin", 32'(allowin), 32'd1);
        check("rst_dest",    32'(dest),    32'd0);
        check("rst_rdata1",  rdata1,       32'd0);
        check("rst_dbg_pc",  dbg_pc,       32'd0);
        check("rst_dbg_we",  32'(dbg_we),  32'd0);
        check("rst_cnt",     cnt,          32'd0);
        rst_n = 1'b1;
        step();

        // Basic write to x5.
        drive(5'd5, 1'b1, 32'hDEADBEEF, 32'h1C000010);
        step();
        mem_over = 1'b0; raddr1 = 5'd5;
        #1;
        check("basic_we",    32'(dbg_we),   32'd1);
        check("basic_wnum",  32'(dbg_wnum), 32'd5);
        check("basic_wdata", dbg_wdata,     32'hDEADBEEF);
        check("basic_pc",    dbg_pc,        32'h1C000010);
        check("basic_dest",  32'(dest),     32'd5);
        check("basic_same",  rdata1,        BYP ? 32'hDEADBEEF : 32'd0);
        step();
        check("basic_rd",    rdata1,        32'hDEADBEEF);
        check("basic_cnt",   cnt,           32'd1);
        check("basic_idle_pc", dbg_pc,      32'd0);

        // Write to x0 is dropped but still retires.
        drive(5'd0, 1'b1, 32'h12345678, 32'h1C000014);
        step();
        mem_over = 1'b0; raddr1 = 5'd0;
        #1;
        check("x0_we",   32'(dbg_we),   32'd0);
        check("x0_wnum", 32'(dbg_wnum), 32'd0);
        check("x0_rd",   rdata1,        32'd0);
        step();
        check("x0_rd2",  rdata1,        32'd0);
        check("x0_cnt",  cnt,           32'd2);

        // Stall with x3=0xA5 in WB while upstream offers x9.
        drive(5'd3, 1'b1, 32'h000000A5, 32'h1C000018);
        step();
        stall = 1'b1; raddr1 = 5'd3;
        drive(5'd9, 1'b1, 32'h0000BEEF, 32'h1C00001C);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_allowin", 32'(allowin), 32'd0);
            check("stall_we",      32'(dbg_we),  32'd0);
            check("stall_dest",    32'(dest),    32'd3);
            check("stall_cnt",     cnt,          32'd2);
            check("stall_rd",      rdata1,       32'd0);
            step();
        end
        stall = 1'b0;
        #1;
        check("unstall_allowin", 32'(allowin),   32'd1);
        check("unstall_wnum",    32'(dbg_wnum),  32'd3);
        step();
        mem_over = 1'b0;
        #1;
        check("unstall_rd",   rdata1,        32'h000000A5);
        check("unstall_cnt",  cnt,           32'd3);
        check("next_wnum",    32'(dbg_wnum), 32'd9);
        raddr1 = 5'd9;
        step();
        check("next_rd",  rdata1, 32'h0000BEEF);
        check("next_cnt", cnt,    32'd4);

        // Same-cycle read of the register being committed.
        drive(5'd7, 1'b1, 32'h000055AA, 32'h1C000020);
        step();
        mem_over = 1'b0; raddr2 = 5'd7;
        #1;
        check("byp_rd2",  rdata2, BYP ? 32'h000055AA : 32'd0);
        step();
        check("byp_rd2b", rdata2, 32'h000055AA);

        // Back-to-back writes to x10; last one wins.
        raddr1 = 5'd10;
        drive(5'd10, 1'b1, 32'h1, 32'h1C000024);
        step();
        drive(5'd10, 1'b1, 32'h2, 32'h1C000028);
        step();
        mem_over = 1'b0;
        #1;
        check("b2b_mid",  rdata1, BYP ? 32'h2 : 32'h1);
        step();
        check("b2b_last", rdata1, 32'h2);
        check("b2b_cnt",  cnt,    32'd7);

        // Stall with an empty WB keeps allowin high.
        stall = 1'b1;
        #1;
        check("bubble_allowin", 32'(allowin), 32'd1);
        drive(5'd11, 1'b1, 32'h11, 32'h1C00002C);
        step();
        mem_over = 1'b0; raddr1 = 5'd11;
        #1;
        check("bubble_fill_allowin", 32'(allowin), 32'd0);
        check("bubble_cnt",          cnt,          32'd7);
        stall = 1'b0;
        step();
        check("bubble_rd",  rdata1, 32'h11);
        check("bubble_cnt2", cnt,   32'd8);

        // Async reset with a write to x5 pending.
        drive(5'd5, 1'b1, 32'h0000CAFE, 32'h1C000030);
        step();
        mem_over = 1'b0; raddr1 = 5'd5;
        #1;
        check("pre_rst_we", 32'(dbg_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_allowin", 32'(allowin),  32'd1);
        check("arst_dest",    32'(dest),     32'd0);
        check("arst_we",      32'(dbg_we),   32'd0);
        check("arst_pc",      dbg_pc,        32'd0);
        check("arst_wdata",   dbg_wdata,     32'd0);
        check("arst_cnt",     cnt,           32'd0);
        check("arst_rd",      rdata1,        32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_rd",  rdata1, 32'd0);
        check("post_rst_cnt", cnt,    32'd0);

        // Counter wrap on the 4-bit copy: 16 back-to-back we=0 retires.
        drive(5'd1, 1'b0, 32'h0, 32'h1C000040);
        for (int i = 0; i < 16; i++) begin
            step();
        end
        check("wrap_pre_w", 32'(w_cnt), 32'd15);
        check("wrap_pre",   cnt,        32'd15);
        mem_over = 1'b0;
        step();
        check("wrap_w",   32'(w_cnt), 32'd0);
        check("wrap_wide", cnt,       32'd16);
        check("wrap_rd1", rdata1,     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
